// File: rtl/asym_ram_pkg.sv
// Shared constants and width/ratio helpers for the asymmetric RAM and FIFO.
package asym_ram_pkg;

    localparam bit LANE_LSB_FIRST = 1'b1;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic int ratio(input int a, input int b);
        return (a > b) ? a / b : b / a;
    endfunction

endpackage

// File: rtl/asym_sdp_ram_if.sv
// Write/read bus of the asymmetric simple dual-port RAM.
interface asym_sdp_ram_if #(
    parameter int WR_DATA_WIDTH = 8,
    parameter int RD_DATA_WIDTH = 32,
    parameter int WR_ADDR_WIDTH = 7,
    parameter int RD_ADDR_WIDTH = 5
);
    logic                     wr_port_ena;
    logic                     wr_en;
    logic [WR_ADDR_WIDTH-1:0] wr_addr;
    logic [WR_DATA_WIDTH-1:0] wr_data;
    logic                     rd_port_ena;
    logic                     rd_en;
    logic [RD_ADDR_WIDTH-1:0] rd_addr;
    logic [RD_DATA_WIDTH-1:0] rd_data;
    logic                     rd_valid;

    modport master (
        output wr_port_ena, wr_en, wr_addr, wr_data,
        output rd_port_ena, rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_port_ena, wr_en, wr_addr, wr_data,
        input  rd_port_ena, rd_en, rd_addr,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/asym_sdp_ram_lane.sv
// One MIN_W-wide lane of the asymmetric RAM: reset-free array, read-first,
// registered read output with synchronous reset (maps onto a BRAM output register).
module sdp_ram_lane #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Separate process reads the pre-edge contents, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/asym_sdp_ram.sv
// Single-clock asymmetric simple dual-port RAM built from RATIO narrow lanes.
// Define ASYM_SDP_RAM_OUT_REG_EN for an extra output register stage (latency 2).
module asym_sdp_ram
    import asym_ram_pkg::*;
#(
    parameter int WR_DATA_WIDTH = 8,
    parameter int RD_DATA_WIDTH = 32,
    parameter int WR_DEPTH      = 128,
    parameter int WR_ADDR_WIDTH = 7,
    parameter int RD_DEPTH      = 32,
    parameter int RD_ADDR_WIDTH = 5
) (
    input logic           clk,
    input logic           rst,
    asym_sdp_ram_if.slave bus
);
    localparam int MIN_W   = (WR_DATA_WIDTH < RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH;
    localparam int RATIO   = ratio(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int LOG_R   = $clog2(RATIO);
    localparam bit WR_WIDE = WR_DATA_WIDTH >= RD_DATA_WIDTH;
    localparam bit RD_WIDE = RD_DATA_WIDTH >= WR_DATA_WIDTH;
    localparam int LANE_AW = WR_WIDE ? WR_ADDR_WIDTH : RD_ADDR_WIDTH;

    if (!is_pow2(RATIO)) begin : g_bad_ratio
        $error("asym_sdp_ram: width ratio %0d is not a power of two", RATIO);
    end
    if (WR_DEPTH * WR_DATA_WIDTH != RD_DEPTH * RD_DATA_WIDTH) begin : g_bad_size
        $error("asym_sdp_ram: write and read capacities differ");
    end
    if (WR_ADDR_WIDTH != $clog2(WR_DEPTH)) begin : g_bad_wr_aw
        $error("asym_sdp_ram: WR_ADDR_WIDTH must equal clog2(WR_DEPTH)");
    end
    if (RD_ADDR_WIDTH != $clog2(RD_DEPTH)) begin : g_bad_rd_aw
        $error("asym_sdp_ram: RD_ADDR_WIDTH must equal clog2(RD_DEPTH)");
    end

    logic                     wr_fire;
    logic                     rd_fire;
    logic                     rd_v1;
    logic [LANE_AW-1:0]       lane_waddr;
    logic [LANE_AW-1:0]       lane_raddr;
    logic                     lane_we    [RATIO];
    logic [MIN_W-1:0]         lane_wdata [RATIO];
    logic [MIN_W-1:0]         lane_q     [RATIO];
    logic [RD_DATA_WIDTH-1:0] rd_word;

    assign wr_fire = bus.wr_port_ena & bus.wr_en & ~rst;
    assign rd_fire = bus.rd_port_ena & bus.rd_en;

    for (genvar i = 0; i < RATIO; i++) begin : g_lane
        localparam int POS = LANE_LSB_FIRST ? i : RATIO - 1 - i;

        if (WR_WIDE) begin : g_wr_wide
            assign lane_we[i]    = wr_fire;
            assign lane_wdata[i] = bus.wr_data[POS*MIN_W +: MIN_W];
        end else begin : g_wr_narrow
            assign lane_we[i]    = wr_fire && (bus.wr_addr[LOG_R-1:0] == LOG_R'(i));
            assign lane_wdata[i] = bus.wr_data;
        end

        if (RD_WIDE) begin : g_rd_wide
            assign rd_word[POS*MIN_W +: MIN_W] = lane_q[i];
        end

        sdp_ram_lane #(
            .WIDTH      (MIN_W),
            .ADDR_WIDTH (LANE_AW)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .we    (lane_we[i]),
            .waddr (lane_waddr),
            .wdata (lane_wdata[i]),
            .re    (rd_fire),
            .raddr (lane_raddr),
            .rdata (lane_q[i])
        );
    end

    if (WR_WIDE) begin : g_waddr_wide
        assign lane_waddr = bus.wr_addr;
    end else begin : g_waddr_narrow
        assign lane_waddr = bus.wr_addr[WR_ADDR_WIDTH-1:LOG_R];
    end

    if (RD_WIDE) begin : g_raddr_wide
        assign lane_raddr = bus.rd_addr;
    end else begin : g_raddr_narrow
        // Lane select is registered alongside the lane outputs so it stalls with them.
        logic [LOG_R-1:0] sel_q;
        always_ff @(posedge clk) begin
            if (rst)          sel_q <= '0;
            else if (rd_fire) sel_q <= bus.rd_addr[LOG_R-1:0];
        end
        assign lane_raddr = bus.rd_addr[RD_ADDR_WIDTH-1:LOG_R];
        assign rd_word    = lane_q[sel_q];
    end

    always_ff @(posedge clk) begin
        if (rst)                  rd_v1 <= 1'b0;
        else if (bus.rd_port_ena) rd_v1 <= bus.rd_en;
    end

`ifdef ASYM_SDP_RAM_OUT_REG_EN
    logic [RD_DATA_WIDTH-1:0] rd_d2;
    logic                     rd_v2;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_d2 <= '0;
            rd_v2 <= 1'b0;
        end else if (bus.rd_port_ena) begin
            rd_v2 <= rd_v1;
            if (rd_v1) rd_d2 <= rd_word;
        end
    end

    assign bus.rd_data  = rd_d2;
    assign bus.rd_valid = rd_v2;
`else
    assign bus.rd_data  = rd_word;
    assign bus.rd_valid = rd_v1;
`endif
endmodule
